seq_run_tracker: RTL and testbench

Downstream consumer of the serial sequence-detector output z. It counts each detection event, a rising edge of z. It measures how many cycles each event stays asserted and holds the longest run seen. Results are registered, sized for direct hookup to display/hex decoders, and cleared by a synchronous clear or the system reset.

---
 rtl/seq_run_tracker.sv | 117 +++++++++++
 tb/tb_seq_run_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_run_tracker.sv
// seq_run_tracker: statistics for a serial detector output z.
// It counts rising edges of z, measures the length of each high run,
// and holds the longest completed run. Every output is a flop, so no
// combinational path exists from z or clr to any output.
module seq_run_tracker #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             z,
  input  logic             clr,
  output logic [CNT_W-1:0] event_cnt,
  output logic [LEN_W-1:0] cur_len,
  output logic [LEN_W-1:0] max_len,
  output logic             active,
  output logic             new_event,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_next;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] max_next;
  logic             new_next;
  logic             ovf_next;

  // State and statistics registers; reset lands in IDLE so a z already
  // high at reset release is counted as a fresh event.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      event_cnt <= '0;
      cur_len   <= '0;
      max_len   <= '0;
      active    <= 1'b0;
      new_event <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      event_cnt <= cnt_next;
      cur_len   <= len_next;
      max_len   <= max_next;
      active    <= (state_next == RUN);
      new_event <= new_next;
      overflow  <= ovf_next;
    end
  end

  // Next-state logic; clr takes priority and parks in WAIT_LOW while z
  // is still high so a run that straddles the clear is never counted.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = z ? WAIT_LOW : IDLE;
    end else begin
      case (state)
        IDLE, DONE: state_next = z ? RUN : IDLE;
        RUN:        if (!z) state_next = DONE;
        WAIT_LOW:   if (!z) state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Next values of the statistics registers for the current state and z.
  always_comb begin
    cnt_next = event_cnt;
    len_next = cur_len;
    max_next = max_len;
    new_next = 1'b0;
    ovf_next = overflow;
    if (clr) begin
      cnt_next = '0;
      len_next = '0;
      max_next = '0;
      ovf_next = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (z) begin
            len_next = LEN_W'(1);
            new_next = 1'b1;
            if (event_cnt == CNT_MAX) begin
              ovf_next = 1'b1;
            end else begin
              cnt_next = event_cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (z) begin
            if (cur_len != LEN_MAX) begin
              len_next = cur_len + LEN_W'(1);
            end
          end else if (cur_len > max_len) begin
            max_next = cur_len;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_run_tracker.sv
// Directed testbench for seq_run_tracker. Two instances share stimulus:
// a default-width one and a narrow one (CNT_W=2, LEN_W=3) that exercises
// counter and run-length saturation.
module tb_seq_run_tracker;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       z = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] event_cnt, cur_len, max_len;
  logic       active, new_event, overflow;
  logic [1:0] s_event_cnt;
  logic [2:0] s_cur_len, s_max_len;
  logic       s_active, s_new_event, s_overflow;

  int checks = 0;
  int failures = 0;
  int pulses;
  int s_pulses;

  always #5 Clk = ~Clk;

  seq_run_tracker #(.CNT_W(8), .LEN_W(8)) dut (
    .Clk(Clk), .reset(reset), .z(z), .clr(clr),
    .event_cnt(event_cnt), .cur_len(cur_len), .max_len(max_len),
    .active(active), .new_event(new_event), .overflow(overflow)
  );

  seq_run_tracker #(.CNT_W(2), .LEN_W(3)) dut_s (
    .Clk(Clk), .reset(reset), .z(z), .clr(clr),
    .event_cnt(s_event_cnt), .cur_len(s_cur_len), .max_len(s_max_len),
    .active(s_active), .new_event(s_new_event), .overflow(s_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply z for one clock and sample 1 time unit after the edge.
  task automatic step(input logic zv);
    z = zv;
    @(posedge Clk);
    #1;
    pulses   += int'(new_event);
    s_pulses += int'(s_new_event);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(z);
    clr = 1'b0;
  endtask

  initial begin
    pulses = 0;
    s_pulses = 0;
    // Reset state
    repeat (2) @(posedge Clk);
    #3 reset = 1'b1;
    repeat (5) step(1'b0);
    chk("rst_cnt", event_cnt, 0);
    chk("rst_len", cur_len, 0);
    chk("rst_max", max_len, 0);
    chk("rst_active", active, 0);
    chk("rst_new", new_event, 0);
    chk("rst_ovf", overflow, 0);
    $display("txn reset: cnt=%0d len=%0d max=%0d", event_cnt, cur_len, max_len);

    // Run of 3
    step(1'b1);
    chk("r3_new1", new_event, 1); chk("r3_cnt1", event_cnt, 1);
    chk("r3_act1", active, 1);    chk("r3_len1", cur_len, 1);
    step(1'b1);
    chk("r3_new2", new_event, 0); chk("r3_len2", cur_len, 2);
    step(1'b1);
    chk("r3_len3", cur_len, 3);   chk("r3_act3", active, 1);
    chk("r3_max_mid", max_len, 0);
    step(1'b0);
    chk("r3_act_fall", active, 0); chk("r3_max", max_len, 3);
    chk("r3_len_hold", cur_len, 3);
    step(1'b0);
    chk("r3_cnt", event_cnt, 1);   chk("r3_len_idle", cur_len, 3);
    $display("txn run3: cnt=%0d len=%0d max=%0d", event_cnt, cur_len, max_len);

    // Runs 4, 2, 6 separated by two low cycles
    do_clr();
    chk("clr_cnt", event_cnt, 0); chk("clr_max", max_len, 0); chk("clr_len", cur_len, 0);
    repeat (4) step(1'b1);
    step(1'b0); step(1'b0);
    chk("r4_max", max_len, 4);
    repeat (2) step(1'b1);
    chk("r2_len", cur_len, 2);
    step(1'b0); step(1'b0);
    chk("r2_max", max_len, 4);
    repeat (6) step(1'b1);
    chk("r6_max_mid", max_len, 4);
    step(1'b0);
    chk("r6_max", max_len, 6); chk("r6_cnt", event_cnt, 3); chk("r6_len", cur_len, 6);
    chk("r6_s_max", s_max_len, 6);
    $display("txn runs4_2_6: cnt=%0d len=%0d max=%0d", event_cnt, cur_len, max_len);

    // Pattern 1,1,0,1,1,1,0 through DONE
    step(1'b0);
    do_clr();
    pulses = 0;
    step(1'b1); step(1'b1); step(1'b0);
    step(1'b1);
    chk("done_new", new_event, 1); chk("done_cnt", event_cnt, 2);
    step(1'b1); step(1'b1); step(1'b0);
    chk("pat_cnt", event_cnt, 2); chk("pat_len", cur_len, 3);
    chk("pat_max", max_len, 3);   chk("pat_pulses", pulses, 2);
    $display("txn pattern: cnt=%0d len=%0d max=%0d pulses=%0d", event_cnt, cur_len, max_len, pulses);

    // Counter saturation on the narrow instance
    step(1'b0);
    do_clr();
    s_pulses = 0;
    step(1'b1); step(1'b0); chk("sat_cnt1", s_event_cnt, 1);
    step(1'b1); step(1'b0); chk("sat_cnt2", s_event_cnt, 2);
    step(1'b1); step(1'b0); chk("sat_cnt3", s_event_cnt, 3);
    chk("sat_ovf3", s_overflow, 0);
    step(1'b1);
    chk("sat_ovf4", s_overflow, 1); chk("sat_cnt4", s_event_cnt, 3);
    chk("sat_new4", s_new_event, 1);
    step(1'b0);
    step(1'b1); step(1'b0);
    chk("sat_cnt5", s_event_cnt, 3); chk("sat_ovf5", s_overflow, 1);
    chk("sat_pulses", s_pulses, 5);  chk("sat_wide_cnt", event_cnt, 5);
    chk("sat_wide_ovf", overflow, 0);
    do_clr();
    chk("sat_clr_cnt", s_event_cnt, 0); chk("sat_clr_ovf", s_overflow, 0);
    chk("sat_clr_max", s_max_len, 0);
    $display("txn saturate: s_cnt=%0d s_ovf=%0d pulses=%0d", s_event_cnt, s_overflow, s_pulses);

    // Run-length saturation on the narrow instance
    repeat (10) step(1'b1);
    chk("lsat_len", s_cur_len, 7); chk("lsat_wide_len", cur_len, 10);
    step(1'b0);
    chk("lsat_max", s_max_len, 7); chk("lsat_wide_max", max_len, 10);
    $display("txn lensat: s_len=%0d len=%0d", s_cur_len, cur_len);

    // clr during a run with z still high
    step(1'b0);
    step(1'b1); step(1'b1);
    chk("clrrun_pre", event_cnt, 2);
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    chk("clrrun_cnt", event_cnt, 0); chk("clrrun_act", active, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("wl_cnt", event_cnt, 0); chk("wl_act", active, 0); chk("wl_new", new_event, 0);
    end
    step(1'b0);
    step(1'b1);
    chk("clrrun_next_cnt", event_cnt, 1); chk("clrrun_next_new", new_event, 1);
    $display("txn clr_in_run: cnt=%0d active=%0d", event_cnt, active);

    // Asynchronous reset mid-run
    step(1'b1);
    chk("ar_pre_len", cur_len, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_cnt", event_cnt, 0); chk("ar_len", cur_len, 0);
    chk("ar_act", active, 0);    chk("ar_max", max_len, 0);
    #1 reset = 1'b1;
    step(1'b1);
    chk("ar_rel_cnt", event_cnt, 1); chk("ar_rel_new", new_event, 1);
    chk("ar_rel_act", active, 1);
    $display("txn async_reset: cnt=%0d active=%0d", event_cnt, active);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
